adc_emu: RTL and testbench
==========================

Name: adc_emu

Overview:
- Synthesizable ADC responder that replays a stored ECG record over the same convst/busy/data/data-ready handshake the sample manager drives toward the physical ADC.
- Lets the FPGA run the detection chain on known records without the external converter.
- Samples are preloaded through a write port into an internal RAM and returned one per conversion request.
- Playback wraps at a programmable record length.

Parameters:
- DATA_WIDTH, 12, width of one sample.
- DEPTH, 4096, sample RAM entries; ADDR_WIDTH = $clog2(DEPTH), local.
- CONV_CYCLES, 400, emulated conversion time in i_clk cycles (4 us at 100 MHz); must be >= 1.

Ports:
- i_clk  in  1  system clock; single clock domain.
- i_rst  in  1  asynchronous reset, active-high.
- i_en  in  1  accept new conversion requests.
- i_convst  in  1  conversion start; rising edge, i_clk-synchronous.
- o_busy  out  1  conversion in progress.
- o_data  out  DATA_WIDTH  converted sample; held until next completion.
- o_data_rdy  out  1  one-cycle pulse, o_data valid.
- i_wr_en  in  1  RAM write strobe.
- i_wr_addr  in  ADDR_WIDTH  RAM write address.
- i_wr_data  in  DATA_WIDTH  RAM write data.
- i_rec_len  in  ADDR_WIDTH+1  record length in samples, 0..DEPTH.
- i_restart  in  1  synchronous pulse, read pointer := 0.
- i_ovr_clr  in  1  clear sticky overrun.
- o_overrun  out  1  sticky: convst edge arrived while not IDLE.
- o_wrap  out  1  one-cycle pulse when pointer wraps to 0.

Behaviour:
- Reset: state IDLE, read pointer 0, o_busy 0, o_data 0, o_data_rdy 0, o_overrun 0, o_wrap 0. RAM contents are not reset.
- Edge detect: register i_convst each cycle. edge = i_convst & ~prev. prev resets to 0.
- FSM states: IDLE, CONVERT, FETCH, DONE.
- IDLE: on edge with i_en=1 and i_rec_len!=0, go to CONVERT and load counter = CONV_CYCLES-1. An edge with i_en=0 or i_rec_len=0 is ignored, with no overrun.
- CONVERT: decrement counter. At 0, go to FETCH.
- FETCH: present the read pointer to the RAM; address latched here. Go to DONE.
- DONE: o_data <= RAM output; o_data_rdy=1; advance pointer; go to IDLE.
- Outputs are registered:
  - o_busy=1 exactly in CONVERT and FETCH.
  - o_data_rdy=1 exactly in DONE.
  - o_busy and o_data_rdy are never high together.
- Latency: edge seen in cycle t gives o_busy high in cycles t+1 .. t+CONV_CYCLES+1. o_data_rdy fires in t+CONV_CYCLES+2. o_data is valid from that cycle.
- Pointer advance in DONE:
  - if ptr >= i_rec_len-1, ptr := 0 and o_wrap pulses in the following cycle;
  - otherwise ptr := ptr+1.
  - The >= compare covers i_rec_len shrinking below the current ptr.
- i_restart: ptr := 0 in any state, with priority over the DONE advance, and no o_wrap. A conversion already past FETCH returns the latched address's sample.
- Overrun: an edge in CONVERT, FETCH or DONE sets o_overrun and is otherwise dropped.
  - i_ovr_clr clears o_overrun.
  - If set and clear coincide, set wins.
- i_en falling mid-conversion: the in-flight conversion completes normally.
- RAM: simple dual-port, 1-cycle registered read.
  - Write and read of the same address in the same cycle returns old data (read-first).
  - Writes are allowed in any state.
- Asserting i_rst mid-conversion aborts it immediately: no o_data_rdy, all outputs at reset values.

Decomposition:
- alg_pkg holds:
  - adc_emu_state_t enum {IDLE, CONVERT, FETCH, DONE};
  - constant ADC_EMU_CONV_CYCLES = 400;
  - constant ADC_EMU_DEPTH = 4096.
- Sub-module adc_emu_ram: parameterized simple dual-port read-first RAM (DATA_WIDTH, DEPTH), inferred as block RAM.
- FSM, counter, pointer and edge detect live in adc_emu.

Test Plan (CONV_CYCLES=4, DEPTH=16, DATA_WIDTH=12):
- Reset, then preload addr 0..3 = 0x100,0x101,0x102,0x103, rec_len=4, i_en=1, convst rising at t=10 -> o_busy high t=11..15, o_data_rdy at t=16 with o_data=0x100.
- Six conversions with rec_len=4 -> data 0x100,0x101,0x102,0x103,0x100,0x101; o_wrap one pulse, in the cycle after the 0x103 o_data_rdy.
- Second convst edge 2 cycles after the first -> o_overrun=1, only one o_data_rdy; i_ovr_clr pulse -> o_overrun=0; a simultaneous edge-during-busy with i_ovr_clr -> o_overrun stays 1.
- i_restart asserted in the DONE cycle of sample 0x102 -> returns 0x102, next conversion returns 0x100, no o_wrap.
- rec_len=0 or i_en=0 with convst edges -> o_busy never rises, o_overrun stays 0; i_rst pulse during CONVERT -> o_busy=0 next cycle, no o_data_rdy, next conversion returns addr 0 data.
- Write addr 1 = 0xABC in the FETCH cycle reading addr 1 -> returns old 0x101; the following wrap-around read of addr 1 returns 0xABC.

Source files
------------

// File: rtl/alg_pkg.sv
// Shared types and defaults for the ADC emulator.
// Holds the FSM state encoding and the default sizing.
package alg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        FETCH,
        DONE
    } adc_emu_state_t;

    localparam int ADC_EMU_CONV_CYCLES = 400;
    localparam int ADC_EMU_DEPTH       = 4096;

endpackage

// File: rtl/adc_emu_ram.sv
// Simple dual-port sample RAM, read-first, 1-cycle registered read.
// The read register doubles as the held sample output.
module adc_emu_ram
    import alg_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = ADC_EMU_DEPTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Separate process so a same-address write returns the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (rd_en) begin
            q <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/adc_emu.sv
// ADC responder replaying a stored record over convst/busy/data_rdy.
// FSM, conversion counter, read pointer and edge detect live here.
module adc_emu
    import alg_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int DEPTH       = ADC_EMU_DEPTH,
    parameter int CONV_CYCLES = ADC_EMU_CONV_CYCLES,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_convst,
    output logic                  o_busy,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_rdy,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH:0]   i_rec_len,
    input  logic                  i_restart,
    input  logic                  i_ovr_clr,
    output logic                  o_overrun,
    output logic                  o_wrap
);

    localparam int CNT_W = $clog2(CONV_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'(CONV_CYCLES - 1);

    adc_emu_state_t        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  prev_q;
    logic                  busy_q, busy_d;
    logic                  rdy_q, rdy_d;
    logic                  wrap_q, wrap_d;
    logic                  ovr_q, ovr_d;
    logic                  rd_en;
    logic                  conv_edge;
    logic                  last;

    assign conv_edge = i_convst & ~prev_q;

    // ptr+1 >= len is ptr >= len-1 without underflow at len=0.
    assign last = ({1'b0, ptr_q} + (ADDR_WIDTH + 1)'(1))
                  >= i_rec_len;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        wrap_d  = 1'b0;
        ovr_d   = ovr_q;
        rd_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (conv_edge && i_en && i_rec_len != '0) begin
                    state_d = CONVERT;
                    cnt_d   = CNT_LOAD;
                end
            end
            CONVERT: begin
                if (cnt_q == '0) begin
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FETCH: begin
                rd_en   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                if (last) begin
                    ptr_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (i_restart) begin
            ptr_d  = '0;
            wrap_d = 1'b0;
        end

        if (conv_edge && state_q != IDLE) begin
            ovr_d = 1'b1;
        end else if (i_ovr_clr) begin
            ovr_d = 1'b0;
        end

        busy_d = (state_d == CONVERT) || (state_d == FETCH);
        rdy_d  = (state_d == DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            prev_q  <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            wrap_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            prev_q  <= i_convst;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            wrap_q  <= wrap_d;
            ovr_q   <= ovr_d;
        end
    end

    adc_emu_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (i_wr_en),
        .wr_addr (i_wr_addr),
        .wr_data (i_wr_data),
        .rd_en   (rd_en),
        .rd_addr (ptr_q),
        .q       (o_data)
    );

    assign o_busy     = busy_q;
    assign o_data_rdy = rdy_q;
    assign o_wrap     = wrap_q;
    assign o_overrun  = ovr_q;

endmodule

// File: tb/tb_adc_emu.sv
// Self-checking bench for adc_emu against a record-replay model.
// Small config: 4-cycle conversion, 16-entry RAM, 12-bit samples.
module tb_adc_emu;

    localparam int DW    = 12;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int C     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          convst;
    logic          busy;
    logic [DW-1:0] data;
    logic          data_rdy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW:0]   rec_len;
    logic          restart;
    logic          ovr_clr;
    logic          overrun;
    logic          wrap;

    logic [DW-1:0] mem_m [DEPTH];
    int            ptr_m;
    int            passed = 0;
    int            total  = 0;

    always #5 clk = ~clk;

    adc_emu #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .CONV_CYCLES (C)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_convst   (convst),
        .o_busy     (busy),
        .o_data     (data),
        .o_data_rdy (data_rdy),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_rec_len  (rec_len),
        .i_restart  (restart),
        .i_ovr_clr  (ovr_clr),
        .o_overrun  (overrun),
        .o_wrap     (wrap)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input int a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        cyc();
        wr_en   = 1'b0;
        mem_m[a] = d;
    endtask

    // One full conversion from IDLE: timeline, data and wrap.
    task automatic do_conv(input string nm);
        logic [DW-1:0] exp_d;
        logic          exp_w;
        exp_d = mem_m[ptr_m];
        exp_w = (ptr_m >= int'(rec_len) - 1);
        convst = 1'b1;
        cyc();
        convst = 1'b0;
        for (int k = 1; k <= C + 1; k++) begin
            total++;
            if (busy !== 1'b1 || data_rdy !== 1'b0)
                $display("FAIL %s t+%0d busy/rdy: got %b%b want 10",
                         nm, k, busy, data_rdy);
            else passed++;
            cyc();
        end
        total++;
        if (data_rdy !== 1'b1 || busy !== 1'b0)
            $display("FAIL %s done busy/rdy: got %b%b want 01",
                     nm, busy, data_rdy);
        else passed++;
        total++;
        if (data !== exp_d)
            $display("FAIL %s data: got %h want %h", nm, data, exp_d);
        else passed++;
        ptr_m = exp_w ? 0 : ptr_m + 1;
        cyc();
        total++;
        if (wrap !== exp_w || data_rdy !== 1'b0)
            $display("FAIL %s wrap/rdy: got %b%b want %b0",
                     nm, wrap, data_rdy, exp_w);
        else passed++;
        total++;
        if (data !== exp_d)
            $display("FAIL %s data hold: got %h want %h",
                     nm, data, exp_d);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        total++;
        if ({busy, data_rdy, overrun, wrap} !== 4'b0 || data !== '0)
            $display("FAIL reset: got %b%b%b%b/%h want 0000/000",
                     busy, data_rdy, overrun, wrap, data);
        else passed++;
        rst = 1'b0;
        cyc();
        total++;
        if ({busy, data_rdy, overrun, wrap} !== 4'b0 || data !== '0)
            $display("FAIL post_reset: got %b%b%b%b/%h want 0000/000",
                     busy, data_rdy, overrun, wrap, data);
        else passed++;
        ptr_m = 0;
    endtask

    task automatic test_first_conv();
        for (int a = 0; a < 4; a++)
            write_mem(a, DW'(12'h100 + a));
        for (int a = 4; a < DEPTH; a++)
            write_mem(a, DW'($urandom));
        rec_len = 5'd4;
        en      = 1'b1;
        cyc();
        do_conv("first");
    endtask

    task automatic test_wrap();
        int wraps;
        wraps = 0;
        for (int i = 0; i < 5; i++) begin
            if (ptr_m == 3) wraps++;
            do_conv("wrap_seq");
        end
        total++;
        if (wraps != 1 || ptr_m != 2)
            $display("FAIL wrap_count: got %0d/%0d want 1/2",
                     wraps, ptr_m);
        else passed++;
    endtask

    task automatic test_overrun();
        int            n;
        logic [DW-1:0] got;
        logic [DW-1:0] exp_d;
        exp_d = mem_m[ptr_m];
        n = 0;
        got = '0;
        convst = 1'b1; cyc();
        convst = 1'b0; cyc();
        convst = 1'b1; cyc();
        convst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (data_rdy) begin n++; got = data; end
            cyc();
        end
        total++;
        if (n != 1 || got !== exp_d || overrun !== 1'b1)
            $display("FAIL overrun: got n=%0d d=%h ovr=%b want 1/%h/1",
                     n, got, overrun, exp_d);
        else passed++;
        ptr_m = ptr_m + 1;
        ovr_clr = 1'b1; cyc();
        ovr_clr = 1'b0;
        total++;
        if (overrun !== 1'b0)
            $display("FAIL ovr_clr: got %b want 0", overrun);
        else passed++;
        exp_d = mem_m[ptr_m];
        n = 0;
        convst = 1'b1; cyc();
        convst = 1'b0; cyc(); cyc();
        convst = 1'b1;
        ovr_clr = 1'b1;
        cyc();
        convst = 1'b0;
        ovr_clr = 1'b0;
        total++;
        if (overrun !== 1'b1)
            $display("FAIL ovr_set_wins: got %b want 1", overrun);
        else passed++;
        for (int k = 0; k < 12; k++) begin
            if (data_rdy) begin n++; got = data; end
            cyc();
        end
        total++;
        if (n != 1 || got !== exp_d)
            $display("FAIL ovr_second: got n=%0d d=%h want 1/%h",
                     n, got, exp_d);
        else passed++;
        ptr_m = 0;
        ovr_clr = 1'b1; cyc();
        ovr_clr = 1'b0;
    endtask

    task automatic test_restart();
        logic [DW-1:0] exp_d;
        do_conv("pre_restart0");
        do_conv("pre_restart1");
        exp_d = mem_m[ptr_m];
        convst = 1'b1; cyc();
        convst = 1'b0;
        repeat (C + 1) cyc();
        total++;
        if (data_rdy !== 1'b1 || data !== exp_d)
            $display("FAIL restart_done: got %b/%h want 1/%h",
                     data_rdy, data, exp_d);
        else passed++;
        restart = 1'b1; cyc();
        restart = 1'b0;
        total++;
        if (wrap !== 1'b0)
            $display("FAIL restart_wrap: got %b want 0", wrap);
        else passed++;
        ptr_m = 0;
        do_conv("after_restart");
    endtask

    task automatic test_ignored();
        int seen;
        seen = 0;
        for (int m = 0; m < 2; m++) begin
            if (m == 0) rec_len = '0;
            else begin rec_len = 5'd4; en = 1'b0; end
            for (int i = 0; i < 3; i++) begin
                convst = 1'b1; cyc();
                convst = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    if (busy || data_rdy || overrun) seen++;
                    cyc();
                end
            end
            total++;
            if (seen != 0)
                $display("FAIL ignored_%0d: got %0d active cycles want 0",
                         m, seen);
            else passed++;
        end
        en = 1'b1;
    endtask

    task automatic test_rst_mid();
        int n;
        n = 0;
        convst = 1'b1; cyc();
        convst = 1'b0; cyc(); cyc();
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || data_rdy !== 1'b0)
            $display("FAIL rst_mid: got %b%b want 00", busy, data_rdy);
        else passed++;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < C + 4; k++) begin
            if (data_rdy || busy) n++;
            cyc();
        end
        total++;
        if (n != 0)
            $display("FAIL rst_abort: got %0d active cycles want 0", n);
        else passed++;
        ptr_m = 0;
        do_conv("after_rst");
    endtask

    task automatic test_ram_rw();
        logic [DW-1:0] old_d;
        old_d = mem_m[ptr_m];
        convst = 1'b1; cyc();
        convst = 1'b0;
        repeat (C) cyc();
        wr_en   = 1'b1;
        wr_addr = AW'(ptr_m);
        wr_data = 12'hABC;
        cyc();
        wr_en = 1'b0;
        total++;
        if (data_rdy !== 1'b1 || data !== old_d)
            $display("FAIL read_first: got %b/%h want 1/%h",
                     data_rdy, data, old_d);
        else passed++;
        mem_m[ptr_m] = 12'hABC;
        ptr_m = ptr_m + 1;
        cyc();
        for (int i = 0; i < 4; i++) do_conv("after_write");
        total++;
        if (data !== 12'hABC)
            $display("FAIL new_word: got %h want abc", data);
        else passed++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0, 1: write_mem(int'($urandom_range(0, DEPTH - 1)),
                                DW'($urandom));
                2: begin
                    rec_len = 5'($urandom_range(1, DEPTH));
                    cyc();
                end
                3: begin
                    restart = 1'b1; cyc();
                    restart = 1'b0;
                    ptr_m = 0;
                end
                4: begin
                    en = 1'b0;
                    convst = 1'b1; cyc();
                    convst = 1'b0; cyc();
                    total++;
                    if (busy !== 1'b0)
                        $display("FAIL rand_en_off: got %b want 0", busy);
                    else passed++;
                    en = 1'b1;
                end
                default: do_conv("random");
            endcase
        end
        total++;
        if (overrun !== 1'b0)
            $display("FAIL rand_overrun: got %b want 0", overrun);
        else passed++;
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        convst  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rec_len = '0;
        restart = 1'b0;
        ovr_clr = 1'b0;
        test_reset();
        test_first_conv();
        test_wrap();
        test_overrun();
        test_restart();
        test_ignored();
        test_rst_mid();
        test_ram_rw();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
